// File: rtl/irrigation_scheduler_if.sv
// irrigation_scheduler_if: control, sensor and status signals of the irrigation scheduler
interface irrigation_scheduler_if #(parameter int SEL_W = 2);
    logic clk_1hz, time_wr, slot_wr, slot_en_set, rain, moisture_dry, sequencer_active;
    logic [10:0] time_set, slot_time;
    logic [SEL_W-1:0] slot_sel;
    logic auto_cycle_start, peak_time, rain_hold, pending;
    logic [10:0] minute_of_day;
    logic [7:0] skip_count;
    modport master(
        output clk_1hz, time_wr, time_set, slot_wr, slot_sel, slot_time, slot_en_set,
               rain, moisture_dry, sequencer_active,
        input  auto_cycle_start, minute_of_day, peak_time, rain_hold, pending, skip_count
    );
    modport slave(
        input  clk_1hz, time_wr, time_set, slot_wr, slot_sel, slot_time, slot_en_set,
               rain, moisture_dry, sequencer_active,
        output auto_cycle_start, minute_of_day, peak_time, rain_hold, pending, skip_count
    );
endinterface

// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: minute-of-day clock, start-time slots and start-pulse issue; IRRIG_SCHED_RAIN_HOLD_EN adds post-rain hold-off
module irrigation_scheduler #(
    parameter int NUM_SLOTS     = 4,
    parameter int SEL_W         = 2,
    parameter int TICKS_PER_MIN = 60,
    parameter int RAIN_HOLD_MIN = 120,
    parameter int PEAK_START    = 600,
    parameter int PEAK_END      = 960
) (
    input logic clk,
    input logic rst,
    irrigation_scheduler_if.slave bus
);
    localparam int PW = TICKS_PER_MIN > 1 ? $clog2(TICKS_PER_MIN) : 1;

    logic s1, s2, s3, edge_1hz, wrap, min_tick, hit, trig;
    logic [PW-1:0] presc;
    logic [10:0] slot_t [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_e;
    logic [SEL_W-1:0] sel;
    logic [1:0] inc;
    logic [8:0] skip_sum;

    assign sel      = bus.slot_sel;
    assign edge_1hz = s2 & ~s3;
    assign wrap     = edge_1hz && presc == PW'(TICKS_PER_MIN - 1);
    assign trig     = min_tick & hit;
    assign inc      = {1'b0, trig & (bus.rain_hold | ~bus.moisture_dry | bus.pending)} +
                      {1'b0, bus.rain & bus.pending};
    assign skip_sum = {1'b0, bus.skip_count} + {7'b0, inc};
    assign bus.peak_time = bus.minute_of_day >= 11'(PEAK_START) && bus.minute_of_day < 11'(PEAK_END);

    // Synchronise clk_1hz, prescale its edges and advance the minute-of-day counter
    always_ff @(posedge clk) begin
        {s3, s2, s1} <= rst ? 3'b0 : {s2, s1, bus.clk_1hz};
        presc <= (rst || bus.time_wr) ? '0 : edge_1hz ? (wrap ? '0 : presc + PW'(1)) : presc;
        bus.minute_of_day <= rst ? '0 : bus.time_wr ? bus.time_set :
                             wrap ? (bus.minute_of_day == 11'd1439 ? '0 : bus.minute_of_day + 11'd1) :
                             bus.minute_of_day;
        min_tick <= ~rst & wrap & ~bus.time_wr;
    end

    // Slot table; a match evaluated in the same cycle still sees the old contents
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_e <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) slot_t[i] <= '0;
        end else if (bus.slot_wr) begin
            slot_t[sel] <= bus.slot_time;
            slot_e[sel] <= bus.slot_en_set;
        end
    end

    // Any number of matching enabled slots collapses into a single hit
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) hit = hit | (slot_e[i] && slot_t[i] == bus.minute_of_day);
    end

    // Resolve triggers into the pending flag, issue the start pulse and count dropped starts
    always_ff @(posedge clk) begin
        bus.pending <= rst || bus.rain ? 1'b0 :
                       bus.pending ? bus.sequencer_active :
                       trig & ~bus.rain_hold & bus.moisture_dry;
        bus.auto_cycle_start <= ~rst & bus.pending & ~bus.sequencer_active & ~bus.rain;
        bus.skip_count <= rst ? '0 : skip_sum[8] ? 8'hFF : skip_sum[7:0];
    end

`ifdef IRRIG_SCHED_RAIN_HOLD_EN
    localparam int HW = RAIN_HOLD_MIN > 0 ? $clog2(RAIN_HOLD_MIN + 1) : 1;
    logic [HW-1:0] hold;
    assign bus.rain_hold = bus.rain | (hold != '0);

    // Hold-off minutes after rain clears, reloaded for as long as it rains
    always_ff @(posedge clk) begin
        hold <= rst ? '0 : bus.rain ? HW'(RAIN_HOLD_MIN) :
                (min_tick && hold != '0) ? hold - HW'(1) : hold;
    end
`else
    logic unused_rain_hold_min;
    assign unused_rain_hold_min = ^RAIN_HOLD_MIN;
    assign bus.rain_hold = bus.rain;
`endif
endmodule

// File: doc/irrigation_scheduler.md
# irrigation_scheduler

Time-of-day scheduler directly upstream of `smart_irrigation`. Derives a minute-of-day clock from the slow `clk_1hz` input, holds a small table of programmable start times, and issues the single-cycle `auto_cycle_start` that launches the zone sequencer. Cycles are suppressed by rain, a post-rain hold-off and wet soil. A start is deferred, never duplicated, while the sequencer is busy.

## Interface
Parameters:
- `NUM_SLOTS`, 4: number of programmable start-time slots.
- `SEL_W`, 2: slot index width. Must equal clog2(`NUM_SLOTS`).
- `TICKS_PER_MIN`, 60: `clk_1hz` rising edges per minute. Benches use 1.
- `RAIN_HOLD_MIN`, 120: minutes of hold-off after rain clears.
- `PEAK_START`, 600: first minute of the peak window (10:00).
- `PEAK_END`, 960: first minute after the peak window (16:00).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `clk_1hz`  in  1  slow asynchronous timebase, level input.
- `time_wr`  in  1  load `time_set` into the minute-of-day counter.
- `time_set`  in  11  minute-of-day value, 0..1439.
- `slot_wr`  in  1  write the slot addressed by `slot_sel`.
- `slot_sel`  in  SEL_W  slot index.
- `slot_time`  in  11  start minute for the written slot.
- `slot_en_set`  in  1  enable bit for the written slot.
- `rain`  in  1  rain sensor, level.
- `moisture_dry`  in  1  soil-dry indication, level.
- `sequencer_active`  in  1  busy flag from `smart_irrigation`.
- `auto_cycle_start`  out  1  one-cycle start pulse to `smart_irrigation`.
- `minute_of_day`  out  11  current time of day.
- `peak_time`  out  1  asserted while `PEAK_START` <= `minute_of_day` < `PEAK_END`.
- `rain_hold`  out  1  asserted while rain is present or the post-rain hold-off is running.
- `pending`  out  1  a start is queued and waiting for the sequencer to go idle.
- `skip_count`  out  8  saturating count of suppressed or coalesced starts.

## Operation
- **Timebase**
  - `clk_1hz` passes through a 2-flop synchronizer and a rising-edge detector.
  - Each detected edge increments a prescaler over 0..`TICKS_PER_MIN`-1.
  - On wrap, `minute_of_day` increments and the block raises an internal `min_tick`.
  - `minute_of_day` wraps from 1439 to 0.
- **time_wr**
  - Loads `minute_of_day` and clears the prescaler.
  - Wins over a simultaneous increment.
  - Raises no `min_tick`, so loading a time never triggers a start.
- **Slots**
  - `slot_wr` writes the time and enable bit of the addressed slot.
  - When `slot_wr` coincides with a match evaluation, the evaluation uses the pre-write contents.
- **Match**
  - In the cycle after `min_tick`, the block compares `minute_of_day` with every enabled slot.
  - Any number of matching slots produces exactly one trigger.
- **Trigger resolution** (first applicable rule wins):
  - `rain_hold`=1: skip, `skip_count`+1.
  - `moisture_dry`=0: skip, `skip_count`+1.
  - `pending` already 1: coalesce, `skip_count`+1.
  - Otherwise: `pending` <= 1.
- **Issue**
  - When `pending`=1 and `sequencer_active`=0, the block asserts `auto_cycle_start` on the next edge for exactly one cycle and clears `pending`.
  - While `sequencer_active`=1, `pending` holds with no timeout.
- **Rain**
  - `rain`=1 clears `pending` and adds 1 to `skip_count` if `pending` was set.
  - `rain`=1 also reloads the hold counter to `RAIN_HOLD_MIN`.
  - While `rain`=0, the hold counter decrements on each `min_tick` and stops at 0.
  - `rain_hold` = `rain` OR (hold counter != 0).
- **skip_count** saturates at 255.

## Timing
- **Reset values:**
  - `minute_of_day`=0, prescaler=0.
  - All slots disabled with time 0.
  - `pending`=0, `auto_cycle_start`=0, `skip_count`=0, hold counter=0.
  - `peak_time`=0, `rain_hold`=`rain`.
- **Latency**, counted from edge E0, the first clock edge that samples `clk_1hz` high:
  - Edge detected after E1.
  - `minute_of_day` updates at E2 (when the prescaler wraps).
  - Trigger resolved and `pending` set at E3.
  - `auto_cycle_start` high E4–E5, provided `sequencer_active`=0 at E3.
- `peak_time` and `rain_hold` are combinational from registered state.
- `clk_1hz` high or low phases shorter than 2 `clk` periods are not guaranteed to register.
- Reset mid-operation discards any queued start. Reset asserted during an `auto_cycle_start` pulse forces it low on the next edge.

## Configuration
- `IRRIG_SCHED_RAIN_HOLD_EN` defined:
  - Post-rain hold counter present, as described above.
- `IRRIG_SCHED_RAIN_HOLD_EN` undefined:
  - Hold counter removed, `rain_hold` = `rain`.
  - A start whose slot matches one minute after rain clears is issued normally.
  - `RAIN_HOLD_MIN` is ignored.

## Test plan
All scenarios use `TICKS_PER_MIN`=1.
- **Basic start:** `time_set`=598, slot0=600 enabled, `moisture_dry`=1. Apply 2 `clk_1hz` pulses → `minute_of_day`=600, `peak_time`=1, exactly one `auto_cycle_start` 2 cycles after the update.
- **Busy sequencer:** slot match while `sequencer_active`=1 → `pending`=1, no pulse. Drop `sequencer_active` → single pulse on the next edge, `pending`=0.
- **Suppression:** slot match with `moisture_dry`=0 → no pulse, `skip_count`=1. Slots 1 and 2 both set to 700, with a match while `pending` is set → `skip_count` becomes 2, still one pulse when the sequencer idles.
- **Rain hold:** `rain`=1 then 0, `RAIN_HOLD_MIN`=3, slot at minute +2 → skipped. Slot at minute +4 → issued. Undefine the macro → slot at minute +2 is issued.
- **Wrap and load:** `time_set`=1439, one pulse → `minute_of_day`=0. `time_wr` to a slot's time → no pulse.
- **Reset:** `rst` while `pending`=1 → all outputs at reset values, no pulse after release.
